// File: rtl/cmp_pkg.sv
// Shared definitions for the magnitude comparator and its result tracker:
// the one-hot result codes, the tracker state encoding and a legality test.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EVT  = 2'd2
  } trk_state_t;

  // Only the three one-hot codes are meaningful; everything else is illegal.
  function automatic logic is_legal_code(input logic [2:0] code);
    return (code == CMP_GT) || (code == CMP_EQ) || (code == CMP_LT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count up on inc, stop at the maximum value, clear has priority.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/cmp_result_tracker.sv
// Consumes comparator result beats, keeps a saturating histogram of
// gt/eq/lt/illegal codes and raises one streak event for every run of
// STREAK_LEN identical legal codes (STREAK_LEN must be 2..255).
module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int STREAK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_result,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] ill_cnt,
  output logic [2:0]       last_code,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_code
);

  // A run reaching this length before the current beat completes a streak.
  localparam logic [7:0] STREAK_M1 = 8'(STREAK_LEN - 1);

  trk_state_t r_state, w_state_nxt;
  logic [2:0] r_run_code, w_run_code_nxt;
  logic [7:0] r_run_len, w_run_len_nxt;
  logic [2:0] r_evt_code, w_evt_code_nxt;
  logic [2:0] r_last_code;
  logic       r_rst_done;

  logic w_accept;
  logic w_xfer;
  logic w_legal;

  assign evt_valid = (r_state == EVT);
  assign evt_code  = r_evt_code;
  assign last_code = r_last_code;
  assign in_ready  = r_rst_done & ~clear & (~evt_valid | evt_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = evt_valid & evt_ready;
  assign w_legal   = is_legal_code(in_result);

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_done <= 1'b0;
    else        r_rst_done <= 1'b1;
  end

  // Tracker state register: FSM state, current run and pending event code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_run_code <= '0;
      r_run_len  <= '0;
      r_evt_code <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_run_code <= w_run_code_nxt;
      r_run_len  <= w_run_len_nxt;
      r_evt_code <= w_evt_code_nxt;
    end
  end

  // Run detection: next state, run bookkeeping and event capture.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt    = r_state;
    w_run_code_nxt = r_run_code;
    w_run_len_nxt  = r_run_len;
    w_evt_code_nxt = r_evt_code;
    if (clear) begin
      w_state_nxt    = IDLE;
      w_run_code_nxt = '0;
      w_run_len_nxt  = '0;
      w_evt_code_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && w_legal) begin
            w_state_nxt    = RUN;
            w_run_code_nxt = in_result;
            w_run_len_nxt  = 8'd1;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (!w_legal) begin
              w_state_nxt   = IDLE;
              w_run_len_nxt = '0;
            end else if (in_result == r_run_code) begin
              if (r_run_len == STREAK_M1) begin
                w_state_nxt    = EVT;
                w_evt_code_nxt = r_run_code;
                w_run_len_nxt  = '0;
              end else begin
                w_run_len_nxt = r_run_len + 8'd1;
              end
            end else begin
              w_run_code_nxt = in_result;
              w_run_len_nxt  = 8'd1;
            end
          end
        end
        EVT: begin
          // An accept here always coincides with the event transfer.
          if (w_xfer) begin
            if (w_accept && w_legal) begin
              w_state_nxt    = RUN;
              w_run_code_nxt = in_result;
              w_run_len_nxt  = 8'd1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: begin
          w_state_nxt   = IDLE;
          w_run_len_nxt = '0;
        end
      endcase
    end
  end

  // Most recent legal code; illegal beats leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_code <= '0;
    end else if (clear) begin
      r_last_code <= '0;
    end else if (w_accept && w_legal) begin
      r_last_code <= in_result;
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .inc(w_accept && (in_result == CMP_GT)), .cnt(gt_cnt)
  );
  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .inc(w_accept && (in_result == CMP_EQ)), .cnt(eq_cnt)
  );
  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .inc(w_accept && (in_result == CMP_LT)), .cnt(lt_cnt)
  );
  sat_counter #(.W(CNT_W)) u_ill_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .inc(w_accept && !w_legal), .cnt(ill_cnt)
  );

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed bench for cmp_result_tracker. Two instances share all inputs:
// CNT_W = 8 for the main checks and CNT_W = 3 to exercise saturation.
// Expected streak events are queued when the completing beat is driven and
// popped when the event is seen transferring.
module tb_cmp_result_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [2:0] in_result;
  logic       evt_ready;

  logic       in_ready;
  logic [7:0] gt_cnt, eq_cnt, lt_cnt, ill_cnt;
  logic [2:0] last_code;
  logic       evt_valid;
  logic [2:0] evt_code;

  logic       in_ready3;
  logic [2:0] gt3, eq3, lt3, ill3;
  logic [2:0] last_code3;
  logic       evt_valid3;
  logic [2:0] evt_code3;

  int checks = 0;
  int errors = 0;

  // Histogram reference model, updated on each accepted beat.
  int         m_gt, m_eq, m_lt, m_ill;
  logic [2:0] m_last;

  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  cmp_result_tracker #(.CNT_W(8), .STREAK_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .ill_cnt(ill_cnt),
    .last_code(last_code), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code)
  );

  cmp_result_tracker #(.CNT_W(3), .STREAK_LEN(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready3), .in_result(in_result),
    .gt_cnt(gt3), .eq_cnt(eq3), .lt_cnt(lt3), .ill_cnt(ill3),
    .last_code(last_code3), .evt_valid(evt_valid3), .evt_ready(evt_ready),
    .evt_code(evt_code3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic model_clear();
    m_gt = 0; m_eq = 0; m_lt = 0; m_ill = 0; m_last = 3'b000;
  endtask

  task automatic check_hist(input string tag);
    check({tag, "_gt"},   32'(gt_cnt),    32'(m_gt));
    check({tag, "_eq"},   32'(eq_cnt),    32'(m_eq));
    check({tag, "_lt"},   32'(lt_cnt),    32'(m_lt));
    check({tag, "_ill"},  32'(ill_cnt),   32'(m_ill));
    check({tag, "_last"}, 32'(last_code), 32'(m_last));
    check({tag, "_gt3"},  32'(gt3),       32'(sat3(m_gt)));
    check({tag, "_ill3"}, 32'(ill3),      32'(sat3(m_ill)));
  endtask

  // Present one beat, wait (bounded) for in_ready, let it be accepted.
  // Called and returns at posedge+1, so consecutive calls are back-to-back.
  task automatic send(input logic [2:0] code, input bit evt_expected);
    int n = 0;
    in_valid  = 1'b1;
    in_result = code;
    if (evt_expected) exp_q.push_back(code);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_result = 3'($urandom);
    case (code)
      3'b001:  m_gt++;
      3'b010:  m_eq++;
      3'b100:  m_lt++;
      default: m_ill++;
    endcase
    if (code == 3'b001 || code == 3'b010 || code == 3'b100) m_last = code;
  endtask

  // Event monitor: a transfer happens at the edge following this sample.
  always @(negedge clk) begin
    if (rst_n && !clear && evt_valid && evt_ready) begin
      check("evt_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("evt_code", 32'(evt_code), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_result = 3'b000; evt_ready = 1'b1;
    model_clear();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check_hist("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready_first", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Histogram over all three legal codes.
    send(3'b001, 0); send(3'b010, 0); send(3'b100, 0); send(3'b010, 0);
    check_hist("hist");
    check("hist_no_evt", 32'(evt_valid), 32'd0);

    // Streak of four 010 after a breaking 001.
    send(3'b001, 0);
    for (int i = 1; i <= 4; i++) begin
      send(3'b010, i == 4);
      check("streak_evt_valid", 32'(evt_valid), 32'(i == 4));
    end
    check("streak_evt_code", 32'(evt_code), 32'b010);
    for (int i = 0; i < 3; i++) begin
      send(3'b010, 0);
      check("restart_no_evt", 32'(evt_valid), 32'd0);
    end

    // Run broken by a different legal code.
    send(3'b100, 0); send(3'b100, 0); send(3'b100, 0); send(3'b001, 0);
    for (int i = 1; i <= 4; i++) begin
      send(3'b100, i == 4);
      check("break_evt_valid", 32'(evt_valid), 32'(i == 4));
    end

    // Run broken by an illegal code.
    send(3'b100, 0); send(3'b100, 0); send(3'b100, 0);
    send(3'b111, 0);
    check("ill_last_kept", 32'(last_code), 32'b100);
    send(3'b100, 0);
    check("ill_no_evt", 32'(evt_valid), 32'd0);
    check_hist("ill");

    // Backpressure: event held while evt_ready is low.
    evt_ready = 1'b0;
    send(3'b100, 0); send(3'b100, 0); send(3'b100, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_evt_valid", 32'(evt_valid), 32'd1);
      check("bp_evt_code", 32'(evt_code), 32'b100);
    end
    @(posedge clk);
    #1;
    evt_ready = 1'b1;
    send(3'b001, 0);
    check("bp_after_evt_valid", 32'(evt_valid), 32'd0);
    check_hist("bp");

    // Saturation on the 3-bit instance; events on beats 4 and 8.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    check_hist("clr1");
    for (int i = 1; i <= 9; i++) begin
      send(3'b001, (i == 4) || (i == 8));
      check("sat_evt_valid", 32'(evt_valid), 32'((i == 4) || (i == 8)));
    end
    check_hist("sat");
    check("sat_gt3_max", 32'(gt3), 32'd7);

    // Clear with an event pending and a beat presented.
    evt_ready = 1'b0;
    send(3'b001, 0); send(3'b001, 0); send(3'b001, 0);
    check("clr_pending", 32'(evt_valid), 32'd1);
    clear = 1'b1; in_valid = 1'b1; in_result = 3'b010;
    @(negedge clk);
    check("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    model_clear();
    check("clr_evt_valid", 32'(evt_valid), 32'd0);
    check_hist("clr2");
    evt_ready = 1'b1;

    // Asynchronous reset mid-run.
    send(3'b100, 0); send(3'b100, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_evt_valid", 32'(evt_valid), 32'd0);
    check_hist("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      send(3'b100, i == 4);
      check("arst_run_evt", 32'(evt_valid), 32'(i == 4));
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
Name: cmp_result_tracker

Overview:
- Downstream consumer of the 2-bit comparator's 3-bit one-hot result code: 001 = a>b, 010 = a=b, 100 = a<b.
- Accepts result beats over a valid/ready handshake and keeps a saturating histogram of gt/eq/lt/illegal codes.
- Detects runs of STREAK_LEN identical legal codes and emits one streak event per completed run on a one-deep valid/ready output.

Parameters:
- CNT_W, 8: width of each histogram counter.
- STREAK_LEN, 4: identical consecutive legal codes needed for a streak event; legal range 2..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of counters, run state and pending event.
- in_valid  in  1  result beat valid.
- in_ready  out  1  tracker can accept a beat.
- in_result  in  3  comparator code.
- gt_cnt, eq_cnt, lt_cnt, ill_cnt  out  CNT_W each  histogram counters.
- last_code  out  3  most recent legal code accepted.
- evt_valid  out  1  streak event pending.
- evt_ready  in  1  event consumer ready.
- evt_code  out  3  code that formed the streak.

Behaviour:
- Reset (rst_n low, asynchronous) forces all outputs and state to 0.
  - Counters, last_code, evt_valid and evt_code are 0; run length is 0; FSM is IDLE.
  - in_ready is 0 while rst_n is low and 1 from the first cycle after release.
- Handshake: accept = in_valid & in_ready.
  - in_ready = !clear & (!evt_valid | evt_ready).
  - Event transfer = evt_valid & evt_ready.
  - evt_valid and evt_code hold stable until transferred.
- Code classification:
  - Legal codes are exactly 001, 010 and 100.
  - Every other value (000, 011, 101, 110, 111) is illegal.
- Counter update: on accept, the matching counter increments by 1 on the next edge and saturates at 2^CNT_W-1 with no wrap.
- Latency: counters and last_code update one cycle after accept; evt_valid rises one cycle after the accept that completes a run.
- FSM states:
  - IDLE: no run in progress.
  - RUN: run_code and run_len are held, 1 <= run_len <= STREAK_LEN-1.
  - EVT: event pending, run_len = 0.
- IDLE transitions:
  - Legal accept -> RUN with run_len = 1, run_code = code.
  - Illegal accept -> stay in IDLE.
- RUN transitions:
  - Accept of a code equal to run_code: run_len++.
  - If run_len+1 == STREAK_LEN -> EVT, with evt_valid = 1, evt_code = run_code, run_len = 0.
  - Accept of a different legal code -> RUN with run_len = 1, run_code = new code.
  - Illegal accept -> IDLE.
- EVT transitions:
  - Transfer with no simultaneous accept -> IDLE.
  - Transfer with a simultaneous accept: the new beat is processed as from IDLE; evt_valid stays 1 only if STREAK_LEN were 1, which is excluded.
  - No transfer: in_ready = 0 and the state holds.
- Runs never overlap: after an event the next identical code starts run_len = 1.
- Illegal codes leave last_code unchanged.
- clear has priority over everything:
  - Zeroes counters, last_code, run state and evt_valid.
  - FSM -> IDLE.
  - Any beat presented during clear is not accepted (in_ready = 0).
- Reset asserted mid-run or with an event pending: the event is dropped and there is no partial update.
- in_result is sampled only on accept; its value when in_valid is low is don't-care.

Decomposition:
- Package cmp_pkg:
  - Code constants CMP_GT = 3'b001, CMP_EQ = 3'b010, CMP_LT = 3'b100.
  - Enum typedef trk_state_t {IDLE, RUN, EVT}.
  - Function is_legal_code().
  - The comparator should import the same constants.
- Sub-module sat_counter (parameter W; inputs inc and clr; output cnt), instantiated 4 times.

Test Plan:
- Reset and histogram: release rst_n with evt_ready = 1, then feed 001, 010, 100, 010 back-to-back -> gt = 1, eq = 2, lt = 1, ill = 0, last_code = 010, no event.
- Streak: feed 010 x4 with STREAK_LEN = 4 -> one event, evt_code = 010, one cycle after the 4th accept. Feed 010 x3 more -> no event; the run restarted at 1.
- Run break:
  - 100, 100, 100, 001, 100 x4 -> exactly one event (code 100) after the last beat.
  - 100 x3, 111, 100 -> no event; ill_cnt = 1.
- Backpressure: evt_ready = 0 when the event fires -> in_ready = 0 and evt_code stable for 5 cycles. Raise evt_ready with in_valid high and code 001 -> event transferred and beat accepted in the same cycle, gt_cnt increments.
- Saturation: with CNT_W = 3, feed 9 x 001 -> gt_cnt = 7; two events of code 001 occur (beats 4 and 8).
- Clear and reset mid-operation:
  - Assert clear with an event pending and in_valid high -> all counters 0, evt_valid = 0, beat not counted.
  - Drop rst_n asynchronously mid-run -> outputs 0 before the next edge.
